pcs_rx_gearbox_param: RTL and testbench
=======================================

Name: pcs_rx_gearbox_param

Overview:
Parametrised RX gearbox. Converts IN_W-bit SERDES words, LSB-first, into 66-bit PCS blocks. Supports integrated, rate-limited bit-slip with offset tracking, fill-level visibility, and optional output bit reversal. Sits between the SERDES RX interface and the descrambler/block-sync. Successor to the fixed 16-bit gearbox; legal for any IN_W from 8 to 66.

Parameters:
IN_W, 16, input word width; legal 8..66, so at most one block is emitted per cycle.
SLIP_HOLDOFF, 4, cycles after an accepted slip during which further slip requests are ignored; 0 = no holdoff.
BIT_REV, 0, 1 = reverse bit order of each emitted block (bit 0 ↔ bit 65).
CNT_W, 8, fill counter width; must hold 65+IN_W.

Ports:
clk  in  1  single clock, SERDES RX word rate
rst_n  in  1  asynchronous, active-low reset
rx_data  in  IN_W  SERDES word; bit 0 is oldest on the wire
rx_data_valid  in  1  rx_data qualifier
slip  in  1  request to discard one bit (pulse or level; sampled every cycle)
rx_block  out  66  assembled block; [1:0] = sync header when BIT_REV=0
rx_block_valid  out  1  one-cycle strobe per block
rx_hdr  out  2  copy of rx_block[1:0], registered with rx_block
slip_offset  out  7  accepted slips modulo 66 (0..65)
slip_busy  out  1  high while holdoff is active
slip_ignored  out  1  one-cycle pulse when a slip request is dropped
fill_level  out  CNT_W  bits currently buffered

Behaviour:
- Buffer: BUF_W = 66+IN_W bits, LSB-first; fill = valid bit count; bits at and above fill are always zero.
- Reset (async, rst_n=0): buffer, fill, rx_block, rx_hdr, slip_offset, holdoff counter = 0; rx_block_valid, slip_busy, slip_ignored = 0. Mid-stream reset discards partial data immediately.
- Per-cycle ordering, one registered update:
  1. Slip is accepted iff slip=1, holdoff counter=0 and fill≥1. Accepted: buffer >>1, f1 = fill−1. Otherwise f1 = fill.
  2. Emit iff f1≥66. Block = buf[65:0] (after step 1, bit-reversed if BIT_REV), buffer >>66, f2 = f1−66. Otherwise f2 = f1.
  3. If rx_data_valid: OR rx_data into the buffer at bit f2; fill = f2+IN_W. Otherwise fill = f2.
- Emit is registered: rx_block, rx_hdr and rx_block_valid update at the same edge. No back-pressure; the consumer must always accept.
- Latency (IN_W=16, valid from cycle 0): first rx_block_valid appears after edge 5. Blocks are aligned to the first received bit.
- Invariant: fill ≤ 65+IN_W, so no overflow is possible. Bits are never lost except by accepted slips.
- Slip accepted: slip_offset = (slip_offset==65) ? 0 : slip_offset+1. Holdoff counter loads SLIP_HOLDOFF. slip_busy = (counter≠0), registered.
- Slip refused (holdoff active or fill=0): slip_ignored pulses; no other state changes.
- Holdoff counter decrements each cycle while nonzero, independent of rx_data_valid.
- Slip, emit and load may occur in the same cycle. The ordering above is normative.
- rx_data_valid=0 with slip=1: the slip still applies if accepted.

Decomposition:
- Shared package pcs_10g_pkg: PCS_BLK_W=66, SYNC_DATA=2'b01, SYNC_CTRL=2'b10, and the slip_offset width (7).
- One natural sub-module: pcs_rx_gbx_slip_ctrl. It owns the holdoff counter, accept/ignore decision, slip_offset wrap and slip_busy. The datapath stays in the top level.

Test Plan:
- Continuous 16-bit words, IN_W=16, 33 words of an LSB-first counting bit pattern → exactly 8 blocks matching the reference bit slices; fill_level returns to 0; first valid after edge 5.
- Stream of 66-bit blocks with header 2'b01 preceded by 3 junk bits; issue 3 slips spaced >SLIP_HOLDOFF apart → all subsequent rx_hdr=2'b01; slip_offset=3.
- Slip held high 10 cycles, SLIP_HOLDOFF=4 → accepted on cycles 0, 5; slip_ignored on the other 8 cycles; slip_offset=2.
- 66 accepted slips → slip_offset wraps 65→0; data alignment is identical to 0 slips shifted by one block.
- IN_W=64, BIT_REV=1, valid gaps every 3rd cycle → blocks are the bit-reversed slices; no loss or duplication over 100 blocks.
- Assert rst_n low for one cycle mid-stream (fill=40) → all outputs 0 asynchronously; the next block forms from the first post-reset word.

Source files
------------

// File: rtl/pcs_10g_pkg.sv
// pcs_10g_pkg: shared 10G PCS constants and a block bit-reversal helper.
package pcs_10g_pkg;
   localparam int PCS_BLK_W = 66;
   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;
   localparam int SLIP_OFS_W = 7;
   function automatic logic [PCS_BLK_W-1:0] blk_rev(input logic [PCS_BLK_W-1:0] b);
      for (int i = 0; i < PCS_BLK_W; i++) blk_rev[i] = b[PCS_BLK_W-1-i];
   endfunction
endpackage

// File: rtl/pcs_rx_gbx_slip_ctrl.sv
// pcs_rx_gbx_slip_ctrl: slip accept/ignore decision, holdoff timer and slip offset tracking.
module pcs_rx_gbx_slip_ctrl
   import pcs_10g_pkg::*;
#(
   parameter int SLIP_HOLDOFF = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  slip_i,
   input  logic                  can_slip_i,
   output logic                  accept_o,
   output logic [SLIP_OFS_W-1:0] slip_offset_o,
   output logic                  slip_busy_o,
   output logic                  slip_ignored_o
);
   localparam int HW = (SLIP_HOLDOFF > 0) ? $clog2(SLIP_HOLDOFF + 1) : 1;
   logic [HW-1:0]         hold_q, hold_d;
   logic [SLIP_OFS_W-1:0] ofs_q, ofs_d;
   logic                  busy_q, ign_q;
   always_comb begin
      accept_o = slip_i && (hold_q == '0) && can_slip_i;
      hold_d   = accept_o ? HW'(SLIP_HOLDOFF) : ((hold_q != '0) ? hold_q - 1'b1 : hold_q);
      ofs_d    = accept_o ? ((ofs_q == SLIP_OFS_W'(PCS_BLK_W - 1)) ? '0 : ofs_q + 1'b1) : ofs_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         ofs_q  <= '0;
         busy_q <= 1'b0;
         ign_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         ofs_q  <= ofs_d;
         busy_q <= (hold_d != '0);
         ign_q  <= slip_i && !accept_o;
      end
   end
   assign slip_offset_o  = ofs_q;
   assign slip_busy_o    = busy_q;
   assign slip_ignored_o = ign_q;
endmodule

// File: rtl/pcs_rx_gearbox_param.sv
// pcs_rx_gearbox_param: IN_W-bit LSB-first SERDES words to 66-bit PCS blocks,
// with rate-limited bit slip; order per cycle is slip, then emit, then load.
module pcs_rx_gearbox_param
   import pcs_10g_pkg::*;
#(
   parameter int IN_W         = 16,
   parameter int SLIP_HOLDOFF = 4,
   parameter int BIT_REV      = 0,
   parameter int CNT_W        = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IN_W-1:0]       rx_data,
   input  logic                  rx_data_valid,
   input  logic                  slip,
   output logic [PCS_BLK_W-1:0]  rx_block,
   output logic                  rx_block_valid,
   output logic [1:0]            rx_hdr,
   output logic [SLIP_OFS_W-1:0] slip_offset,
   output logic                  slip_busy,
   output logic                  slip_ignored,
   output logic [CNT_W-1:0]      fill_level
);
   localparam int BUF_W = PCS_BLK_W + IN_W;
   logic [BUF_W-1:0]     sr_q, sr_d, sr_s, sr_e;
   logic [CNT_W-1:0]     fill_q, fill_d, f1, f2;
   logic [PCS_BLK_W-1:0] blk_q, blk_d;
   logic                 vld_q, emit, accept;
   pcs_rx_gbx_slip_ctrl #(.SLIP_HOLDOFF(SLIP_HOLDOFF)) u_slip (
      .clk           (clk),
      .rst_n         (rst_n),
      .slip_i        (slip),
      .can_slip_i    (fill_q != '0),
      .accept_o      (accept),
      .slip_offset_o (slip_offset),
      .slip_busy_o   (slip_busy),
      .slip_ignored_o(slip_ignored)
   );
   // Bits above fill stay zero, so the new word can simply be ORed in at f2.
   always_comb begin
      sr_s   = accept ? sr_q >> 1 : sr_q;
      f1     = accept ? fill_q - 1'b1 : fill_q;
      emit   = f1 >= CNT_W'(PCS_BLK_W);
      sr_e   = emit ? sr_s >> PCS_BLK_W : sr_s;
      f2     = emit ? f1 - CNT_W'(PCS_BLK_W) : f1;
      sr_d   = rx_data_valid ? sr_e | ({{PCS_BLK_W{1'b0}}, rx_data} << f2) : sr_e;
      fill_d = rx_data_valid ? f2 + CNT_W'(IN_W) : f2;
      blk_d  = emit ? ((BIT_REV != 0) ? blk_rev(sr_s[PCS_BLK_W-1:0]) : sr_s[PCS_BLK_W-1:0]) : blk_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q   <= '0;
         fill_q <= '0;
         blk_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         fill_q <= fill_d;
         blk_q  <= blk_d;
         vld_q  <= emit;
      end
   end
   assign rx_block       = blk_q;
   assign rx_block_valid = vld_q;
   assign rx_hdr         = blk_q[1:0];
   assign fill_level     = fill_q;
endmodule

// File: tb/tb_pcs_rx_gearbox_param.sv
// tb_pcs_rx_gearbox_param: two gearbox configurations checked every cycle against a bit-queue model.
module tb_pcs_rx_gearbox_param;
   import pcs_10g_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   int vecs = 0;
   int errs = 0;
   logic [1:0]       v = '0;
   logic [1:0]       s = '0;
   logic [1:0][65:0] d = '0;

   task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int IW   = g ? 64 : 16;
      localparam int HOLD = g ? 0 : 4;
      localparam int REV  = g;
      logic [65:0] blk;
      logic [1:0]  hdr;
      logic [6:0]  ofs;
      logic [7:0]  fill;
      logic        bv, busy, ign;
      pcs_rx_gearbox_param #(.IN_W(IW), .SLIP_HOLDOFF(HOLD), .BIT_REV(REV), .CNT_W(8)) dut (
         .clk(clk), .rst_n(rst_n), .rx_data(d[g][IW-1:0]), .rx_data_valid(v[g]), .slip(s[g]),
         .rx_block(blk), .rx_block_valid(bv), .rx_hdr(hdr), .slip_offset(ofs),
         .slip_busy(busy), .slip_ignored(ign), .fill_level(fill));
      // Model: the buffer is just a FIFO of wire bits, oldest at the front.
      bit q[$];
      int m_ofs, m_hold, nblk;
      logic [65:0] m_blk;
      bit m_v, m_ign, acc;
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q.delete();
            m_ofs = 0; m_hold = 0; nblk = 0; m_blk = '0; m_v = 0; m_ign = 0;
         end else begin
            acc   = s[g] && m_hold == 0 && q.size() > 0;
            m_ign = s[g] && !acc;
            if (acc) begin
               void'(q.pop_front());
               m_ofs  = (m_ofs + 1) % 66;
               m_hold = HOLD;
            end else if (m_hold > 0) m_hold--;
            m_v = q.size() >= 66;
            if (m_v) begin
               for (int i = 0; i < 66; i++) m_blk[REV ? 65 - i : i] = q.pop_front();
               nblk++;
            end
            if (v[g]) for (int i = 0; i < IW; i++) q.push_back(d[g][i]);
         end
      end
      always @(negedge clk) begin
         chk($sformatf("g%0d_valid", g), 66'(bv), 66'(m_v));
         chk($sformatf("g%0d_block", g), blk, m_blk);
         chk($sformatf("g%0d_hdr", g), 66'(hdr), 66'(m_blk[1:0]));
         chk($sformatf("g%0d_offset", g), 66'(ofs), 66'(m_ofs));
         chk($sformatf("g%0d_busy", g), 66'(busy), 66'(m_hold != 0));
         chk($sformatf("g%0d_ignored", g), 66'(ign), 66'(m_ign));
         chk($sformatf("g%0d_fill", g), 66'(fill), 66'(q.size()));
      end
   end

   int cyc = 0;
   task automatic drive1(input bit slips);
      cyc++;
      v[1] = (cyc % 3) != 2;
      d[1] = {$urandom, $urandom, $urandom};
      s[1] = slips && ($urandom_range(0, 15) == 0);
   endtask

   bit st[$];
   int first, nb0, ign_cnt;
   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_fill", 66'(gi[0].fill), 66'd0);
      chk("rst_valid", 66'(gi[0].bv), 66'd0);
      rst_n = 1'b1;
      // Counting words: 33 x 16 bits is exactly 8 blocks.
      first = -1;
      for (int k = 0; k < 33; k++) begin
         v[0] = 1'b1;
         d[0] = 66'(k);
         drive1(1'b0);
         @(negedge clk);
         if (first < 0 && gi[0].bv) first = k;
      end
      v[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin drive1(1'b0); @(negedge clk); end
      chk("first_valid_edge", 66'(first), 66'd5);
      chk("count_blocks", 66'(gi[0].nblk), 66'd8);
      chk("count_fill_empty", 66'(gi[0].fill), 66'd0);
      // Three junk bits ahead of data-header blocks, removed by three slips.
      st = {1'b1, 1'b1, 1'b1};
      for (int b = 0; b < 20; b++) begin
         st.push_back(1'b1);
         st.push_back(1'b0);
         for (int i = 0; i < 64; i++) st.push_back(1'($urandom));
      end
      nb0 = gi[0].nblk;
      v[0] = 1'b1;
      for (int i = 0; i < 16; i++) d[0][i] = st.pop_front();
      drive1(1'b1);
      @(negedge clk);
      v[0] = 1'b0;
      for (int n = 0; n < 3; n++) begin
         s[0] = 1'b1;
         drive1(1'b1);
         @(negedge clk);
         s[0] = 1'b0;
         for (int k = 0; k < 5; k++) begin drive1(1'b1); @(negedge clk); end
      end
      while (st.size() > 0 || gi[0].fill >= 66) begin
         v[0] = st.size() > 0;
         for (int i = 0; i < 16; i++) d[0][i] = (st.size() > 0) ? st.pop_front() : 1'b0;
         drive1(1'b1);
         @(negedge clk);
         if (gi[0].bv) chk("align_hdr", 66'(gi[0].hdr), 66'(SYNC_DATA));
      end
      v[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin drive1(1'b1); @(negedge clk); end
      chk("align_offset", 66'(gi[0].ofs), 66'd3);
      chk("align_blocks", 66'(gi[0].nblk - nb0), 66'd20);
      // Slip held for ten cycles against a holdoff of four.
      ign_cnt = 0;
      v[0] = 1'b1;
      s[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         d[0] = 66'($urandom);
         drive1(1'b1);
         @(negedge clk);
         ign_cnt += int'(gi[0].ign);
      end
      s[0] = 1'b0;
      chk("held_ignored", 66'(ign_cnt), 66'd8);
      chk("held_offset", 66'(gi[0].ofs), 66'd5);
      // 66 back-to-back slips on the no-holdoff instance wrap the offset.
      s[1] = 1'b0;
      v[1] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 66; k++) begin
         int o0;
         if (k == 0) o0 = int'(gi[1].ofs);
         s[1] = 1'b1;
         d[1] = {$urandom, $urandom, $urandom};
         @(negedge clk);
         if (k == 65) chk("wrap_offset", 66'(gi[1].ofs), 66'(o0));
      end
      s[1] = 1'b0;
      // Random traffic with an asynchronous reset pulse midway.
      for (int k = 0; k < 2000; k++) begin
         v[0] = $urandom_range(0, 3) != 0;
         d[0] = 66'($urandom);
         s[0] = $urandom_range(0, 9) == 0;
         drive1(1'b1);
         if (k == 1000) begin
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_fill", 66'(gi[0].fill), 66'd0);
            chk("async_rst_block", gi[1].blk, 66'd0);
            chk("async_rst_offset", 66'(gi[0].ofs), 66'd0);
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
